pe_array_sched: RTL and testbench

//  Scheduler/sequencer for a linear array of NPE stencil PEs (float16 datapath, sel0..sel5 steering).
//  - Sweeps a configured ROWS x COLS grid for ITERS iterations.
//  - Generates per-PE select vectors each cycle.
//  - Paces input streaming with a valid/ready handshake.
//  - Tracks PE pipeline latency to flag valid outputs.
//  - Start/busy/done handshake to the host controller.

---
 rtl/pe_array_sched_pkg.sv | 14 +
 rtl/pe_array_sched_sel_gen.sv | 30 +++
 rtl/pe_array_sched.sv | 134 +++++++++++++
 tb/tb_pe_array_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_sched_pkg.sv
// Shared types and select-bit encodings for the PE array scheduler.
// Select constants name what a PE mux picks when its select bit is 0 or 1.
package pe_sched_pkg;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} sched_state_t;

   localparam logic SEL_IBIAS = 1'b0;
   localparam logic SEL_ZERO  = 1'b1;
   localparam logic SEL_LEFT  = 1'b0;
   localparam logic SEL_FIFO  = 1'b1;
   localparam logic SEL_CUR   = 1'b0;
   localparam logic SEL_PFIFO = 1'b1;

endpackage

// File: rtl/pe_array_sched_sel_gen.sv
// Combinational per-PE select generator: edge PEs get boundary steering,
// iteration flags choose bias injection and the output destination.
module pe_sel_gen
   import pe_sched_pkg::*;
#(
   parameter int NPE = 4
) (
   input  logic           i_use_bias,
   input  logic           i_not_last,
   output logic [NPE-1:0] o_sel0,
   output logic [NPE-1:0] o_sel1,
   output logic [NPE-1:0] o_sel2,
   output logic [NPE-1:0] o_sel3,
   output logic [NPE-1:0] o_sel4,
   output logic [NPE-1:0] o_sel5
);

   genvar gi;
   generate
      for (gi = 0; gi < NPE; gi++) begin : g_pe
         assign o_sel0[gi] = i_use_bias ? SEL_IBIAS : SEL_ZERO;
         assign o_sel1[gi] = (gi == NPE - 1);
         assign o_sel2[gi] = (gi == 0) ? SEL_FIFO : SEL_LEFT;
         assign o_sel3[gi] = (gi == NPE - 1);
         assign o_sel4[gi] = (gi == 0);
         assign o_sel5[gi] = i_not_last ? SEL_PFIFO : SEL_CUR;
      end
   endgenerate

endmodule

// File: rtl/pe_array_sched.sv
// Row/column/iteration sequencer for a linear stencil PE array, with input
// pacing, pipeline-latency tracking of valid outputs and host handshake.
module pe_array_sched
   import pe_sched_pkg::*;
#(
   parameter int NPE      = 4,
   parameter int CW       = 16,
   parameter int PIPE_LAT = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [CW-1:0]  cfg_rows,
   input  logic [CW-1:0]  cfg_cols,
   input  logic [CW-1:0]  cfg_iters,
   input  logic           bias_en,
   input  logic           in_valid,
   output logic           in_ready,
   output logic           out_valid,
   output logic           busy,
   output logic           done,
   output logic [CW-1:0]  row_cnt,
   output logic [CW-1:0]  iter_cnt,
   output logic [NPE-1:0] sel0,
   output logic [NPE-1:0] sel1,
   output logic [NPE-1:0] sel2,
   output logic [NPE-1:0] sel3,
   output logic [NPE-1:0] sel4,
   output logic [NPE-1:0] sel5
);

   localparam int DW = $clog2(PIPE_LAT + 1);

   sched_state_t         r_state;
   logic [CW-1:0]        r_rows_m1, r_cols_m1, r_iters_m1;
   logic [CW-1:0]        r_col_cnt, r_row_cnt, r_iter_cnt;
   logic [DW-1:0]        r_drain_cnt;
   logic [PIPE_LAT-1:0]  r_lat_sr;
   logic                 r_bias_en, r_busy, r_done;
   logic                 w_fire;

   // Limits are stored as value-1 so a zero config acts as one and max never wraps.
   function automatic logic [CW-1:0] lim_m1(input logic [CW-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

   assign in_ready  = (r_state == S_STREAM);
   assign w_fire    = in_valid & in_ready;
   assign out_valid = r_lat_sr[PIPE_LAT-1];
   assign busy      = r_busy;
   assign done      = r_done;
   assign row_cnt   = r_row_cnt;
   assign iter_cnt  = r_iter_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rows_m1   <= '0;
         r_cols_m1   <= '0;
         r_iters_m1  <= '0;
         r_col_cnt   <= '0;
         r_row_cnt   <= '0;
         r_iter_cnt  <= '0;
         r_drain_cnt <= '0;
         r_lat_sr    <= '0;
         r_bias_en   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_lat_sr <= (r_lat_sr << 1) | PIPE_LAT'(w_fire);
         r_done   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_rows_m1  <= lim_m1(cfg_rows);
                  r_cols_m1  <= lim_m1(cfg_cols);
                  r_iters_m1 <= lim_m1(cfg_iters);
                  r_bias_en  <= bias_en;
                  r_col_cnt  <= '0;
                  r_row_cnt  <= '0;
                  r_iter_cnt <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (w_fire) begin
                  if (r_col_cnt == r_cols_m1) begin
                     r_col_cnt   <= '0;
                     r_drain_cnt <= '0;
                     r_state     <= S_DRAIN;
                  end else begin
                     r_col_cnt <= r_col_cnt + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt == DW'(PIPE_LAT - 1)) begin
                  if (r_row_cnt < r_rows_m1) begin
                     r_row_cnt <= r_row_cnt + 1'b1;
                     r_state   <= S_STREAM;
                  end else begin
                     r_row_cnt <= '0;
                     if (r_iter_cnt < r_iters_m1) begin
                        r_iter_cnt <= r_iter_cnt + 1'b1;
                        r_state    <= S_STREAM;
                     end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end
                  end
               end else begin
                  r_drain_cnt <= r_drain_cnt + 1'b1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   pe_sel_gen #(.NPE(NPE)) u_sel_gen (
      .i_use_bias (r_bias_en & (r_iter_cnt == '0)),
      .i_not_last (r_iter_cnt != r_iters_m1),
      .o_sel0     (sel0),
      .o_sel1     (sel1),
      .o_sel2     (sel2),
      .o_sel3     (sel3),
      .o_sel4     (sel4),
      .o_sel5     (sel5)
   );

endmodule

// File: tb/tb_pe_array_sched.sv
// Directed self-checking bench for pe_array_sched (NPE=4, CW=16, PIPE_LAT=2).
module tb_pe_array_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] cfg_rows, cfg_cols, cfg_iters;
   logic        bias_en;
   logic        in_valid;
   logic        in_ready, out_valid, busy, done;
   logic [15:0] row_cnt, iter_cnt;
   logic [3:0]  sel0, sel1, sel2, sel3, sel4, sel5;

   int n_checks = 0;
   int n_errors = 0;

   int          f_row [16];
   int          f_iter[16];
   logic [3:0]  f_sel0[16];
   logic [3:0]  f_sel5[16];
   logic        fire_h[20];
   logic        ov_h  [20];

   int nf, no, nd, nr;

   always #5 clk = ~clk;

   pe_array_sched #(.NPE(4), .CW(16), .PIPE_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_iters(cfg_iters),
      .bias_en(bias_en), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .busy(busy), .done(done),
      .row_cnt(row_cnt), .iter_cnt(iter_cnt),
      .sel0(sel0), .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4), .sel5(sel5)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_edges(input string tag);
      chk({tag, "_sel1"}, 32'(sel1), 32'h8);
      chk({tag, "_sel3"}, 32'(sel3), 32'h8);
      chk({tag, "_sel2"}, 32'(sel2), 32'h1);
      chk({tag, "_sel4"}, 32'(sel4), 32'h1);
   endtask

   // Runs one job with in_valid held high; records per-fire state and counts events.
   task automatic run_job(input logic restart, output int fires, output int ovs, output int dones);
      int seen;
      fires = 0; ovs = 0; dones = 0; seen = -1;
      in_valid = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (seen >= 0 && c > seen + 3) break;
         start = (restart && c == 1);
         if (in_ready && in_valid) begin
            if (fires < 16) begin
               f_row[fires]  = int'(row_cnt);
               f_iter[fires] = int'(iter_cnt);
               f_sel0[fires] = sel0;
               f_sel5[fires] = sel5;
            end
            fires++;
         end
         if (out_valid) ovs++;
         if (done) begin
            dones++;
            if (seen < 0) seen = c;
         end
         step();
      end
      start = 1'b0;
   endtask

   initial begin
      int exp_row [8];
      int exp_iter[8];
      exp_row  = '{0, 0, 1, 1, 0, 0, 1, 1};
      exp_iter = '{0, 0, 0, 0, 1, 1, 1, 1};

      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; bias_en = 1'b0;
      cfg_rows = 16'd1; cfg_cols = 16'd1; cfg_iters = 16'd1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_row", 32'(row_cnt), 0);
      chk("rst_iter", 32'(iter_cnt), 0);
      #22 rst_n = 1'b1;
      step();
      chk_edges("idle");

      // Job 1: 1x3x1 with bias, exact cycle timing.
      cfg_rows = 16'd1; cfg_cols = 16'd3; cfg_iters = 16'd1; bias_en = 1'b1;
      in_valid = 1'b1; start = 1'b1;
      step(); start = 1'b0;
      chk("j1_c1_busy", 32'(busy), 1);
      chk("j1_c1_ready", 32'(in_ready), 1);
      chk("j1_c1_ov", 32'(out_valid), 0);
      chk("j1_sel0", 32'(sel0), 0);
      chk("j1_sel5", 32'(sel5), 0);
      chk_edges("stream");
      step();
      chk("j1_c2_ready", 32'(in_ready), 1);
      chk("j1_c2_ov", 32'(out_valid), 0);
      step();
      chk("j1_c3_ready", 32'(in_ready), 1);
      chk("j1_c3_ov", 32'(out_valid), 1);
      step();
      chk("j1_c4_ready", 32'(in_ready), 0);
      chk("j1_c4_ov", 32'(out_valid), 1);
      chk("j1_c4_busy", 32'(busy), 1);
      chk_edges("drain");
      step();
      chk("j1_c5_ov", 32'(out_valid), 1);
      chk("j1_c5_done", 32'(done), 0);
      step();
      chk("j1_c6_done", 32'(done), 1);
      chk("j1_c6_busy", 32'(busy), 0);
      chk("j1_c6_ov", 32'(out_valid), 0);
      chk_edges("done");
      step();
      chk("j1_c7_done", 32'(done), 0);
      chk("j1_post_sel0", 32'(sel0), 0);
      chk("j1_post_sel5", 32'(sel5), 0);

      // Job 2: 2x2x2 with bias, per-fire row/iter/select tracking.
      cfg_rows = 16'd2; cfg_cols = 16'd2; cfg_iters = 16'd2; bias_en = 1'b1;
      run_job(1'b0, nf, no, nd);
      chk("j2_fires", 32'(nf), 8);
      chk("j2_ovs", 32'(no), 8);
      chk("j2_dones", 32'(nd), 1);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("j2_row%0d", k), 32'(f_row[k]), 32'(exp_row[k]));
         chk($sformatf("j2_iter%0d", k), 32'(f_iter[k]), 32'(exp_iter[k]));
         chk($sformatf("j2_sel5_%0d", k), 32'(f_sel5[k]), (exp_iter[k] == 0) ? 32'hF : 32'h0);
         chk($sformatf("j2_sel0_%0d", k), 32'(f_sel0[k]), (exp_iter[k] == 0) ? 32'h0 : 32'hF);
      end
      chk("j2_iter_hold", 32'(iter_cnt), 1);

      // Job 3: 1x4x1, in_valid alternating; out_valid must trail fires by 2.
      cfg_rows = 16'd1; cfg_cols = 16'd4; cfg_iters = 16'd1; bias_en = 1'b0;
      start = 1'b1; in_valid = 1'b1;
      step(); start = 1'b0;
      nr = 0; nd = 0; nf = 0;
      for (int c = 0; c < 20; c++) begin
         in_valid  = (c % 2 == 0);
         fire_h[c] = in_ready & in_valid;
         ov_h[c]   = out_valid;
         if (in_ready) nr++;
         if (fire_h[c]) nf++;
         if (done) nd++;
         step();
      end
      chk("j3_fires", 32'(nf), 4);
      chk("j3_ready_cycles", 32'(nr), 7);
      chk("j3_dones", 32'(nd), 1);
      chk("j3_ov0", 32'(ov_h[0]), 0);
      chk("j3_ov1", 32'(ov_h[1]), 0);
      for (int c = 2; c < 20; c++)
         chk($sformatf("j3_ov%0d", c), 32'(ov_h[c]), 32'(fire_h[c-2]));

      // Job 4: reset during row 1 stream, then a fresh job.
      cfg_rows = 16'd2; cfg_cols = 16'd2; cfg_iters = 16'd1;
      in_valid = 1'b1; start = 1'b1;
      step(); start = 1'b0;
      step(); step(); step(); step();
      chk("j4_row1", 32'(row_cnt), 1);
      chk("j4_ready", 32'(in_ready), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("j4_rst_busy", 32'(busy), 0);
      chk("j4_rst_ready", 32'(in_ready), 0);
      chk("j4_rst_ov", 32'(out_valid), 0);
      chk("j4_rst_row", 32'(row_cnt), 0);
      chk("j4_rst_done", 32'(done), 0);
      step(); step();
      #2 rst_n = 1'b1;
      nd = 0;
      for (int c = 0; c < 5; c++) begin
         if (done) nd++;
         step();
      end
      chk("j4_no_done", 32'(nd), 0);
      chk("j4_idle_busy", 32'(busy), 0);
      run_job(1'b0, nf, no, nd);
      chk("j4_fresh_fires", 32'(nf), 4);
      chk("j4_fresh_ovs", 32'(no), 4);
      chk("j4_fresh_dones", 32'(nd), 1);

      // Job 5: zero config acts as 1x1x1; a second start while busy is ignored.
      cfg_rows = 16'd0; cfg_cols = 16'd0; cfg_iters = 16'd0; bias_en = 1'b0;
      run_job(1'b1, nf, no, nd);
      chk("j5_fires", 32'(nf), 1);
      chk("j5_ovs", 32'(no), 1);
      chk("j5_dones", 32'(nd), 1);
      chk("j5_idle_busy", 32'(busy), 0);
      chk("j5_sel0", 32'(sel0), 32'hF);
      chk("j5_sel5", 32'(sel5), 0);
      chk_edges("final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
